// File: rtl/i2s_transmitter_if.sv
// i2s_transmitter_if: sample/handshake side and serial side of the I2S transmitter
interface i2s_transmitter_if #(parameter int BITSIZE = 24);
  logic                      lrclk;
  logic                      enable;
  logic signed [BITSIZE-1:0] left_in;
  logic signed [BITSIZE-1:0] right_in;
  logic                      sample_valid;
  logic                      dacdat;
  logic                      sample_req;
  logic                      underrun;
  modport master (output lrclk, enable, left_in, right_in, sample_valid,
                  input dacdat, sample_req, underrun);
  modport slave (input lrclk, enable, left_in, right_in, sample_valid,
                 output dacdat, sample_req, underrun);
endinterface

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: serializes buffered stereo samples MSB-first onto dacdat, framed by lrclk
module i2s_transmitter #(
  parameter int BITSIZE  = 24,
  parameter int SLOTBITS = 32
) (
  input logic          bclk,
  input logic          rst_n,
  i2s_transmitter_if.slave bus
);
  localparam int CW = $clog2(SLOTBITS + 1);
  localparam logic [CW-1:0] BS = CW'(BITSIZE);
  localparam logic [CW-1:0] SB = CW'(SLOTBITS);
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               lr_q;
  logic               pend_v_q, pend_v_d;
  logic [BITSIZE-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [BITSIZE-1:0] hold_r_q, hold_r_d, sh_q, sh_d, load;
  logic               dac_q, dac_d, req_q, req_d, und_q, und_d;
  logic               fall, rise, fstart, cstart, start, bit_nx;
  always_comb begin
    fall     = lr_q & ~bus.lrclk;
    rise     = ~lr_q & bus.lrclk;
    // a fall never restarts a left slot, and a rise only matters while sending left
    fstart   = fall && state_q != LEFT;
    cstart   = rise && state_q == LEFT;
    start    = fstart | cstart;
    state_d  = fstart ? LEFT : cstart ? RIGHT : state_q;
    hold_r_d = fstart ? (pend_v_q ? pend_r_q : '0) : hold_r_q;
    load     = fstart ? (pend_v_q ? pend_l_q : '0) : hold_r_q;
    sh_d     = start ? {load[BITSIZE-2:0], 1'b0} : {sh_q[BITSIZE-2:0], 1'b0};
    bit_nx   = start ? load[BITSIZE-1] : (state_q != IDLE && cnt_q < BS) & sh_q[BITSIZE-1];
    cnt_d    = start ? CW'(1) : (state_q != IDLE && cnt_q < SB) ? cnt_q + CW'(1) : cnt_q;
    dac_d    = bus.enable & bit_nx;
    req_d    = fstart & pend_v_q;
    und_d    = fstart & ~pend_v_q;
    // a sample arriving on a frame start is kept for the next frame, never bypassed
    pend_v_d = bus.sample_valid | (pend_v_q & ~fstart);
    pend_l_d = bus.sample_valid ? bus.left_in : pend_l_q;
    pend_r_d = bus.sample_valid ? bus.right_in : pend_r_q;
  end
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lr_q     <= 1'b0;
      pend_v_q <= 1'b0;
      pend_l_q <= '0;
      pend_r_q <= '0;
      hold_r_q <= '0;
      sh_q     <= '0;
      dac_q    <= 1'b0;
      req_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lr_q     <= bus.lrclk;
      pend_v_q <= pend_v_d;
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      hold_r_q <= hold_r_d;
      sh_q     <= sh_d;
      dac_q    <= dac_d;
      req_q    <= req_d;
      und_q    <= und_d;
    end
  end
  assign bus.dacdat     = dac_q;
  assign bus.sample_req = req_q;
  assign bus.underrun   = und_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: per-slot scoreboard of expected dacdat bits and handshake pulses
module tb_i2s_transmitter;
  logic bclk = 1'b0;
  logic rst_n;
  i2s_transmitter_if #(.BITSIZE(24)) bus ();
  i2s_transmitter #(.BITSIZE(24), .SLOTBITS(32)) dut (.bclk(bclk), .rst_n(rst_n), .bus(bus));
  always #5 bclk = ~bclk;
  typedef struct {
    logic [63:0] bits;
    int          len;
    int          req;
    int          und;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic        pend_v, active;
  logic [23:0] pend_l, pend_r, cur_r;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic slot(input logic lv, input int n, input int sv_at, input logic [23:0] l,
                      input logic [23:0] r, input logic en0, input int mute_at);
    exp_t e;
    logic [23:0] w;
    e.bits = '0;
    e.len  = n;
    e.req  = 0;
    e.und  = 0;
    w      = '0;
    if (!lv) begin
      active = 1'b1;
      e.req  = pend_v ? 1 : 0;
      e.und  = pend_v ? 0 : 1;
      w      = pend_v ? pend_l : 24'h0;
      cur_r  = pend_v ? pend_r : 24'h0;
      pend_v = 1'b0;
    end else if (active) w = cur_r;
    for (int i = 0; i < n && i < 24; i++)
      if (en0 && (mute_at < 0 || i < mute_at)) e.bits[i] = w[23-i];
    sb.push_back(e);
    for (int i = 0; i < n; i++) begin
      bus.lrclk        = lv;
      bus.enable       = en0 && !(mute_at >= 0 && i >= mute_at);
      bus.sample_valid = (i == sv_at);
      bus.left_in      = l;
      bus.right_in     = r;
      if (i == sv_at) begin
        pend_v = 1'b1;
        pend_l = l;
        pend_r = r;
      end
      @(negedge bclk);
    end
    bus.sample_valid = 1'b0;
  endtask
  logic        prev_lr = 1'b0, col = 1'b0, lr_s;
  logic [63:0] mbits;
  int          mn, mrq, mud;
  always @(posedge bclk) begin
    exp_t e;
    lr_s = bus.lrclk;
    #1;
    if (!rst_n) begin
      col     = 1'b0;
      prev_lr = 1'b0;
    end else begin
      if (lr_s != prev_lr) begin
        if (col) begin
          if (sb.size() == 0) check("sb_underflow", 64'(1), 64'(0));
          else begin
            e = sb.pop_front();
            check("slot_len", 64'(mn), 64'(e.len));
            check("slot_bits", mbits, e.bits);
            check("slot_req", 64'(mrq), 64'(e.req));
            check("slot_und", 64'(mud), 64'(e.und));
          end
        end
        col   = 1'b1;
        mn    = 0;
        mrq   = 0;
        mud   = 0;
        mbits = '0;
      end
      prev_lr = lr_s;
      if (col) begin
        if (mn < 64) mbits[mn] = bus.dacdat;
        mn++;
        mrq += int'(bus.sample_req);
        mud += int'(bus.underrun);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    bus.lrclk = 1'b0;
    bus.enable = 1'b1;
    bus.sample_valid = 1'b0;
    bus.left_in = '0;
    bus.right_in = '0;
    pend_v = 1'b0;
    active = 1'b0;
    pend_l = '0;
    pend_r = '0;
    cur_r = '0;
    repeat (3) @(negedge bclk);
    check("rst_dacdat", 64'(bus.dacdat), 64'(0));
    check("rst_req", 64'(bus.sample_req), 64'(0));
    check("rst_und", 64'(bus.underrun), 64'(0));
    rst_n = 1'b1;
    slot(1, 32, 5, 24'h800001, 24'h7FFFFF, 1, -1);
    slot(0, 32, -1, 24'h0, 24'h0, 1, -1);
    slot(1, 32, -1, 24'h0, 24'h0, 1, -1);
    slot(0, 32, -1, 24'h0, 24'h0, 1, -1);
    slot(1, 32, -1, 24'h0, 24'h0, 1, -1);
    slot(0, 32, 0, 24'h000001, 24'h123456, 1, -1);
    slot(1, 32, -1, 24'h0, 24'h0, 1, -1);
    slot(0, 32, -1, 24'h0, 24'h0, 1, -1);
    slot(1, 32, 8, 24'hFFFFFF, 24'hA5A5A5, 1, -1);
    slot(0, 16, -1, 24'h0, 24'h0, 1, -1);
    slot(1, 16, 3, 24'h555555, 24'hAAAAAA, 1, -1);
    slot(0, 16, -1, 24'h0, 24'h0, 1, -1);
    slot(1, 16, 2, 24'hC3C3C3, 24'h3C3C3C, 1, -1);
    slot(0, 32, -1, 24'h0, 24'h0, 1, 10);
    slot(1, 32, -1, 24'h0, 24'h0, 0, -1);
    slot(0, 32, 20, 24'hFFFFFF, 24'hFFFFFF, 0, -1);
    slot(1, 32, -1, 24'h0, 24'h0, 0, -1);
    slot(0, 32, 3, 24'hFFFFFF, 24'hFFFFFF, 1, -1);
    for (int i = 0; i < 6; i++) begin
      bus.lrclk = 1'b1;
      @(negedge bclk);
    end
    check("pre_rst_dacdat", 64'(bus.dacdat), 64'(1));
    rst_n = 1'b0;
    active = 1'b0;
    pend_v = 1'b0;
    #1;
    check("async_rst_dacdat", 64'(bus.dacdat), 64'(0));
    @(negedge bclk);
    for (int i = 0; i < 2; i++) begin
      check("in_rst_dacdat", 64'(bus.dacdat), 64'(0));
      check("in_rst_req", 64'(bus.sample_req), 64'(0));
      @(negedge bclk);
    end
    rst_n = 1'b1;
    slot(1, 20, 4, 24'h0F0F0F, 24'hF0F0F0, 1, -1);
    slot(0, 32, -1, 24'h0, 24'h0, 1, -1);
    slot(1, 32, -1, 24'h0, 24'h0, 1, -1);
    bus.lrclk = 1'b0;
    repeat (4) @(negedge bclk);
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Serializes parallel stereo samples (left/right, BITSIZE bits) onto the I2S DAC data line, driven by bclk and framed by an externally generated lrclk.
- Sits downstream of the effect blocks (echo and others): their parallel outputs feed this block, and its serial output goes to the codec DAC input.
- Holds a single-entry pending buffer with a valid handshake, and flags underrun when a frame starts with no fresh sample.

Parameters:
- BITSIZE, 24, sample width in bits. Samples are signed two's complement and sent MSB-first.
- SLOTBITS, 32, number of bclk periods per half-frame slot. SLOTBITS >= BITSIZE is required.

Ports:
- bclk  input  1  bit clock. It is the only clock, and all logic updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- lrclk  input  1  word select, synchronous to bclk. 0 = left slot, 1 = right slot.
- enable  input  1  when low, zeros are transmitted (mute). Buffering and handshakes continue.
- left_in  input  BITSIZE  signed left sample.
- right_in  input  BITSIZE  signed right sample.
- sample_valid  input  1  one-cycle strobe that captures left_in/right_in into the pending buffer.
- dacdat  output  1  serial data to the codec.
- sample_req  output  1  one-cycle pulse when the pending buffer is consumed at a frame start.
- underrun  output  1  one-cycle pulse when a frame starts with the pending buffer empty.

Behaviour:
- Clock and reset: one clock (bclk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - dacdat=0, sample_req=0, underrun=0.
  - State=IDLE, bit counter=0, pending_valid=0, lrclk_d=0.
  - Shift registers and pending buffer cleared to 0.
  - Reset mid-frame aborts the current frame immediately.
- Edge detection:
  - lrclk_d registers lrclk every cycle.
  - fall = lrclk_d & ~lrclk; rise = ~lrclk_d & lrclk.
  - An edge is seen on the first rising bclk edge that samples the new lrclk level.
- State machine:
  - IDLE: dacdat=0. On fall, go to LEFT and perform a frame start. A rise in IDLE is ignored, so output never starts mid-frame.
  - LEFT: on rise, go to RIGHT (channel start).
  - RIGHT: on fall, go to LEFT (frame start).
- Frame start (on fall):
  - If pending_valid: copy the pending left/right into the transmit holding registers, clear pending_valid, and pulse sample_req.
  - Else: load zeros into the holding registers and pulse underrun.
  - In the same cycle, drive the left MSB on dacdat and set bit counter=1.
- Channel start (on rise): drive the right MSB on dacdat and set bit counter=1.
- Serial output:
  - dacdat is registered; bit k (MSB=k=0) of the active channel is driven on the k-th cycle after the edge cycle.
  - The codec samples on the following rising bclk, which gives the standard one-bclk I2S delay.
  - Cycles with counter < BITSIZE: next bit MSB-first.
  - Counter in [BITSIZE, SLOTBITS): dacdat=0.
  - Past SLOTBITS with no lrclk edge: dacdat=0 and the counter saturates.
- Early lrclk toggle (slot shorter than BITSIZE): the remaining bits are dropped and the new channel starts immediately.
- enable=0: dacdat is forced to 0 in every state. The FSM, the counter, sample_req and underrun behave normally. Muting takes effect on the next cycle and is not aligned to a frame.
- Pending buffer:
  - sample_valid=1 loads left_in/right_in and sets pending_valid.
  - If already valid, the older sample is overwritten (last write wins; no flag).
- Simultaneous sample_valid and frame start: the current frame takes the previous pending content (or underruns if empty). The new sample becomes pending for the next frame, with no bypass.
- The right-channel word is always the one latched at the same frame start as the left, so no channel tearing is possible.

Test Plan:
- Reset release, then lrclk at 64 bclk/frame, sample_valid with left=24'h800001, right=24'h7FFFFF before the first fall:
  - Left slot: dacdat = 1, twenty-two 0s, 1, then eight 0s.
  - Right slot: dacdat = 0 followed by twenty-three 1s, then eight 0s.
  - sample_req pulses once at the fall.
- No sample_valid between two frame starts -> underrun pulses at the second fall, and both slots transmit all zeros.
- sample_valid (L=24'h000001) in the same cycle as a fall, with pending empty:
  - That frame underruns with zero data.
  - The next frame transmits LSB=1 at slot bit 23 and asserts sample_req.
- lrclk toggling every 16 bclk (short slots) with L=24'hFFFFFF -> only 16 ones are sent per left slot, and the right MSB starts in the cycle the rise is seen.
- enable dropped mid left slot -> dacdat=0 from the next cycle on, while sample_req/underrun pulses continue at each fall.
- Assert rst_n low mid right slot, then release while lrclk is high -> dacdat stays 0 through the rise (IDLE), and transmission resumes only after the next fall.
